ex_mem_pipe_reg: RTL and testbench

EX/MEM pipeline register for the five-stage MIPS32 core. Captures the execute-stage ALU result, zero flag, store data, destination register, branch target and memory/write-back control bits each cycle. Presents them to the memory stage, resolves the branch-taken decision for the PC mux, and supports hazard-unit stall and flush. Also keeps a saturating bubble counter for performance debug.

---
 rtl/ex_mem_pipe_reg_if.sv | 52 +++++
 rtl/ex_mem_pipe_reg.sv | 115 +++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM boundary bundle: EX-side capture inputs, hazard controls and the
// registered MEM-side outputs. The master drives EX, the slave is the register.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              Stall_MEM;
  logic              Flush_MEM;
  logic              Valid_EX;
  logic [DATA_W-1:0] ALU_Result_EX;
  logic              Zero_EX;
  logic [DATA_W-1:0] Write_Data_EX;
  logic [4:0]        Write_Register_EX;
  logic [DATA_W-1:0] Branch_Dest_EX;
  logic              RegWrite_EX;
  logic              MemtoReg_EX;
  logic              MemRead_EX;
  logic              MemWrite_EX;
  logic              Branch_EX;

  logic              Valid_MEM;
  logic [DATA_W-1:0] ALU_Result_MEM;
  logic              Zero_MEM;
  logic [DATA_W-1:0] Write_Data_MEM;
  logic [4:0]        Write_Register_MEM;
  logic [DATA_W-1:0] Branch_Dest_MEM;
  logic              RegWrite_MEM;
  logic              MemtoReg_MEM;
  logic              MemRead_MEM;
  logic              MemWrite_MEM;
  logic              Branch_MEM;
  logic              PCSrc_MEM;
  logic [CNT_W-1:0]  Bubble_Count;

  modport master (
    output Stall_MEM, Flush_MEM, Valid_EX, ALU_Result_EX, Zero_EX, Write_Data_EX,
           Write_Register_EX, Branch_Dest_EX, RegWrite_EX, MemtoReg_EX,
           MemRead_EX, MemWrite_EX, Branch_EX,
    input  Valid_MEM, ALU_Result_MEM, Zero_MEM, Write_Data_MEM, Write_Register_MEM,
           Branch_Dest_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM,
           Branch_MEM, PCSrc_MEM, Bubble_Count
  );

  modport slave (
    input  Stall_MEM, Flush_MEM, Valid_EX, ALU_Result_EX, Zero_EX, Write_Data_EX,
           Write_Register_EX, Branch_Dest_EX, RegWrite_EX, MemtoReg_EX,
           MemRead_EX, MemWrite_EX, Branch_EX,
    output Valid_MEM, ALU_Result_MEM, Zero_MEM, Write_Data_MEM, Write_Register_MEM,
           Branch_Dest_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM,
           Branch_MEM, PCSrc_MEM, Bubble_Count
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, branch-taken resolution and a
// saturating count of cycles in which the MEM slot held a bubble.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  ex_mem_pipe_reg_if.slave    bus
);

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] alu_q,      alu_d;
  logic              zero_q,     zero_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [4:0]        wreg_q,     wreg_d;
  logic [DATA_W-1:0] bdest_q,    bdest_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              branch_q,   branch_d;
  logic [CNT_W-1:0]  bubble_q,   bubble_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    valid_d    = valid_q;
    alu_d      = alu_q;
    zero_d     = zero_q;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;
    bdest_d    = bdest_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    branch_d   = branch_q;
    bubble_d   = bubble_q;

    if (!valid_q && !bus.Stall_MEM)
      bubble_d = sat_inc(bubble_q);

    // Flush overrides stall: datapath still loads, control is forced to a bubble
    if (bus.Flush_MEM || !bus.Stall_MEM) begin
      alu_d      = bus.ALU_Result_EX;
      zero_d     = bus.Zero_EX;
      wdata_d    = bus.Write_Data_EX;
      wreg_d     = bus.Write_Register_EX;
      bdest_d    = bus.Branch_Dest_EX;
      memtoreg_d = bus.MemtoReg_EX;
    end

    if (bus.Flush_MEM) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      branch_d   = 1'b0;
    end else if (!bus.Stall_MEM) begin
      valid_d    = bus.Valid_EX;
      regwrite_d = bus.RegWrite_EX & bus.Valid_EX;
      memread_d  = bus.MemRead_EX  & bus.Valid_EX;
      memwrite_d = bus.MemWrite_EX & bus.Valid_EX;
      branch_d   = bus.Branch_EX   & bus.Valid_EX;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      zero_q     <= 1'b0;
      wdata_q    <= '0;
      wreg_q     <= '0;
      bdest_q    <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      bubble_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      zero_q     <= zero_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
      bdest_q    <= bdest_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      bubble_q   <= bubble_d;
    end
  end

  assign bus.Valid_MEM          = valid_q;
  assign bus.ALU_Result_MEM     = alu_q;
  assign bus.Zero_MEM           = zero_q;
  assign bus.Write_Data_MEM     = wdata_q;
  assign bus.Write_Register_MEM = wreg_q;
  assign bus.Branch_Dest_MEM    = bdest_q;
  assign bus.RegWrite_MEM       = regwrite_q;
  assign bus.MemtoReg_MEM       = memtoreg_q;
  assign bus.MemRead_MEM        = memread_q;
  assign bus.MemWrite_MEM       = memwrite_q;
  assign bus.Branch_MEM         = branch_q;
  assign bus.PCSrc_MEM          = branch_q & zero_q & valid_q;
  assign bus.Bubble_Count       = bubble_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table, reset/bubble sequences and
// randomized traffic against a rule-level reference model.
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ex_mem_pipe_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  ex_mem_pipe_reg_if #(.DATA_W(DATA_W), .CNT_W(2))     sbus ();

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  ex_mem_pipe_reg #(.DATA_W(DATA_W), .CNT_W(2))     dut_small (.Clk(Clk), .Reset(Reset), .bus(sbus));

  typedef struct {
    logic stall, flush, valid;
    logic [31:0] alu;
    logic zero;
    logic [31:0] wd;
    logic [4:0] wr;
    logic [31:0] bd;
    logic rw, m2r, mr, mw, br;
  } in_t;

  typedef struct {
    logic valid;
    logic [31:0] alu;
    logic zero;
    logic [31:0] wd;
    logic [4:0] wr;
    logic [31:0] bd;
    logic rw, m2r, mr, mw, br;
    int unsigned cnt;
  } st_t;

  typedef struct {
    in_t in;
    logic valid;
    logic [31:0] alu;
    logic [4:0] wr;
    logic rw, mw, pcs;
    logic [31:0] bd;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  in_t cur_in;
  st_t model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Result of one clock edge, stated directly from the pipeline-register rules.
  function automatic st_t model_next(st_t s, in_t x, int unsigned cmax);
    st_t n = s;
    if (!s.valid && !x.stall && s.cnt < cmax) n.cnt = s.cnt + 1;
    if (x.flush || !x.stall) begin
      n.alu = x.alu; n.zero = x.zero; n.wd = x.wd; n.wr = x.wr; n.bd = x.bd; n.m2r = x.m2r;
      n.valid = x.flush ? 1'b0 : x.valid;
      n.rw = !x.flush && x.valid && x.rw;
      n.mr = !x.flush && x.valid && x.mr;
      n.mw = !x.flush && x.valid && x.mw;
      n.br = !x.flush && x.valid && x.br;
    end
    return n;
  endfunction

  function automatic st_t zero_state();
    st_t z;
    z.valid = 0; z.alu = 0; z.zero = 0; z.wd = 0; z.wr = 0; z.bd = 0;
    z.rw = 0; z.m2r = 0; z.mr = 0; z.mw = 0; z.br = 0; z.cnt = 0;
    return z;
  endfunction

  task automatic drive(input in_t x);
    cur_in = x;
    bus.Stall_MEM = x.stall; bus.Flush_MEM = x.flush; bus.Valid_EX = x.valid;
    bus.ALU_Result_EX = x.alu; bus.Zero_EX = x.zero; bus.Write_Data_EX = x.wd;
    bus.Write_Register_EX = x.wr; bus.Branch_Dest_EX = x.bd;
    bus.RegWrite_EX = x.rw; bus.MemtoReg_EX = x.m2r; bus.MemRead_EX = x.mr;
    bus.MemWrite_EX = x.mw; bus.Branch_EX = x.br;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 64'(bus.Valid_MEM), 64'(model.valid));
    chk({tag, ".alu"},   64'(bus.ALU_Result_MEM), 64'(model.alu));
    chk({tag, ".zero"},  64'(bus.Zero_MEM), 64'(model.zero));
    chk({tag, ".wdata"}, 64'(bus.Write_Data_MEM), 64'(model.wd));
    chk({tag, ".wreg"},  64'(bus.Write_Register_MEM), 64'(model.wr));
    chk({tag, ".bdest"}, 64'(bus.Branch_Dest_MEM), 64'(model.bd));
    chk({tag, ".rw"},    64'(bus.RegWrite_MEM), 64'(model.rw));
    chk({tag, ".m2r"},   64'(bus.MemtoReg_MEM), 64'(model.m2r));
    chk({tag, ".mr"},    64'(bus.MemRead_MEM), 64'(model.mr));
    chk({tag, ".mw"},    64'(bus.MemWrite_MEM), 64'(model.mw));
    chk({tag, ".br"},    64'(bus.Branch_MEM), 64'(model.br));
    chk({tag, ".pcsrc"}, 64'(bus.PCSrc_MEM), 64'(model.br && model.zero && model.valid));
    chk({tag, ".bubbles"}, 64'(bus.Bubble_Count), 64'(model.cnt));
    if (bus.RegWrite_MEM === 1'b1)
      chk({tag, ".alu_known"}, 64'($isunknown(bus.ALU_Result_MEM)), 64'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model = model_next(model, cur_in, (1 << CNT_W) - 1);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model = zero_state();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic in_t idle_in();
    in_t x;
    x.stall = 0; x.flush = 0; x.valid = 0; x.alu = 0; x.zero = 0; x.wd = 0;
    x.wr = 0; x.bd = 0; x.rw = 0; x.m2r = 0; x.mr = 0; x.mw = 0; x.br = 0;
    return x;
  endfunction

  vec_t vecs[8];
  in_t  t;
  int unsigned c0;

  initial begin
    sbus.Stall_MEM = 0; sbus.Flush_MEM = 0; sbus.Valid_EX = 0;
    sbus.ALU_Result_EX = 0; sbus.Zero_EX = 0; sbus.Write_Data_EX = 0;
    sbus.Write_Register_EX = 0; sbus.Branch_Dest_EX = 0; sbus.RegWrite_EX = 0;
    sbus.MemtoReg_EX = 0; sbus.MemRead_EX = 0; sbus.MemWrite_EX = 0; sbus.Branch_EX = 0;
    drive(idle_in());
    do_reset();
    #1;
    check_model("reset_init");

    // Directed table: normal load, branch taken/not, store, stall x3, stall+flush
    t = idle_in(); t.valid = 1; t.alu = 32'h7; t.wr = 5'd9; t.rw = 1;
    vecs[0] = '{in:t, valid:1, alu:32'h7, wr:5'd9, rw:1, mw:0, pcs:0, bd:32'h0};
    t = idle_in(); t.valid = 1; t.br = 1; t.zero = 1; t.bd = 32'h40;
    vecs[1] = '{in:t, valid:1, alu:32'h0, wr:5'd0, rw:0, mw:0, pcs:1, bd:32'h40};
    t.valid = 0;
    vecs[2] = '{in:t, valid:0, alu:32'h0, wr:5'd0, rw:0, mw:0, pcs:0, bd:32'h40};
    t = idle_in(); t.valid = 1; t.mw = 1; t.wd = 32'hDEAD_BEEF; t.alu = 32'h100; t.wr = 5'd2;
    vecs[3] = '{in:t, valid:1, alu:32'h100, wr:5'd2, rw:0, mw:1, pcs:0, bd:32'h0};
    t = idle_in(); t.stall = 1; t.valid = 1; t.alu = 32'h55; t.wr = 5'd3; t.rw = 1; t.bd = 32'h80;
    for (int i = 4; i < 7; i++)
      vecs[i] = '{in:t, valid:1, alu:32'h100, wr:5'd2, rw:0, mw:1, pcs:0, bd:32'h0};
    t = idle_in(); t.stall = 1; t.flush = 1; t.valid = 1; t.alu = 32'h66; t.wr = 5'd4; t.mw = 1; t.rw = 1;
    vecs[7] = '{in:t, valid:0, alu:32'h66, wr:5'd4, rw:0, mw:0, pcs:0, bd:32'h0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].in);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid_t", i), 64'(bus.Valid_MEM), 64'(vecs[i].valid));
      chk($sformatf("vec%0d.alu_t", i),   64'(bus.ALU_Result_MEM), 64'(vecs[i].alu));
      chk($sformatf("vec%0d.wreg_t", i),  64'(bus.Write_Register_MEM), 64'(vecs[i].wr));
      chk($sformatf("vec%0d.rw_t", i),    64'(bus.RegWrite_MEM), 64'(vecs[i].rw));
      chk($sformatf("vec%0d.mw_t", i),    64'(bus.MemWrite_MEM), 64'(vecs[i].mw));
      chk($sformatf("vec%0d.pcsrc_t", i), 64'(bus.PCSrc_MEM), 64'(vecs[i].pcs));
      chk($sformatf("vec%0d.bdest_t", i), 64'(bus.Branch_Dest_MEM), 64'(vecs[i].bd));
      if (i >= 3 && i <= 6)
        chk($sformatf("vec%0d.wdata_t", i), 64'(bus.Write_Data_MEM), 64'h0000_0000_DEAD_BEEF);
    end

    // Bubble counter: one valid load, then five bubbles counted over six edges
    t = idle_in(); t.valid = 1; t.alu = 32'h1;
    drive(t); tick("bub_load");
    c0 = 32'(bus.Bubble_Count);
    drive(idle_in());
    repeat (6) tick("bub_run");
    chk("bubble_plus5", 64'(bus.Bubble_Count), 64'(c0 + 5));
    t = idle_in(); t.stall = 1;
    drive(t);
    repeat (3) tick("bub_stall");
    chk("bubble_stall_hold", 64'(bus.Bubble_Count), 64'(c0 + 5));

    // Asynchronous reset between edges with all inputs nonzero
    t.stall = 0; t.flush = 0; t.valid = 1; t.alu = 32'hFFFF_FFFF; t.zero = 1; t.wd = 32'h1234_5678;
    t.wr = 5'd31; t.bd = 32'hABCD_0000; t.rw = 1; t.m2r = 1; t.mr = 1; t.mw = 1; t.br = 1;
    drive(t); tick("pre_reset");
    t.stall = 1; t.flush = 1; drive(t);
    @(negedge Clk); #2;
    Reset = 1'b1;
    model = zero_state();
    #1;
    check_model("async_reset");
    chk("async_reset.pcsrc0", 64'(bus.PCSrc_MEM), 64'd0);
    chk("async_reset.bub0", 64'(bus.Bubble_Count), 64'd0);
    chk("small.reset", 64'(sbus.Bubble_Count), 64'd0);
    #1;
    Reset = 1'b0;
    drive(idle_in());

    // Small-counter instance: six bubble edges saturate at 3
    for (int i = 0; i < 6; i++) begin
      tick("small_run");
      chk($sformatf("small.cnt%0d", i), 64'(sbus.Bubble_Count), 64'((i + 1 > 3) ? 3 : i + 1));
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      t.stall = ($urandom_range(0, 4) == 0);
      t.flush = ($urandom_range(0, 6) == 0);
      t.valid = ($urandom_range(0, 3) != 0);
      t.alu = $urandom; t.zero = 1'($urandom); t.wd = $urandom; t.wr = 5'($urandom);
      t.bd = $urandom; t.rw = 1'($urandom); t.m2r = 1'($urandom); t.mr = 1'($urandom);
      t.mw = 1'($urandom); t.br = 1'($urandom);
      drive(t);
      tick("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
